// File: rtl/wb_bram_burst_pkg.sv
// wb_bram_burst_pkg: shared Wishbone burst types, constants and the burst address predictor
package wb_bram_burst_pkg;
  typedef logic [2:0] cti_t;
  typedef logic [1:0] bte_t;
  typedef enum logic [1:0] {IDLE, RD1, BURST} state_t;
  localparam cti_t CTI_CLASSIC = 3'b000;
  localparam cti_t CTI_INCR = 3'b010;
  localparam cti_t CTI_EOB = 3'b111;
  localparam bte_t BTE_LINEAR = 2'b00;
  localparam bte_t BTE_WRAP4 = 2'b01;
  localparam bte_t BTE_WRAP8 = 2'b10;
  localparam bte_t BTE_WRAP16 = 2'b11;
  // Wrapping bursts only advance the low bits; upper bits stay on the same aligned block.
  function automatic logic [31:0] next_adr(input logic [31:0] addr, input bte_t bte);
    return bte == BTE_WRAP4 ? {addr[31:2], addr[1:0] + 2'd1} :
           bte == BTE_WRAP8 ? {addr[31:3], addr[2:0] + 3'd1} :
           bte == BTE_WRAP16 ? {addr[31:4], addr[3:0] + 4'd1} : addr + 32'd1;
  endfunction
endpackage

// File: rtl/bram_sp_bytewe.sv
// bram_sp_bytewe: single-port byte-enable RAM, read-first, one-cycle read latency
module bram_sp_bytewe #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_ADR_WIDTH = 11
) (
  input logic clk,
  input logic [DATA_WIDTH/8-1:0] be,
  input logic [MEM_ADR_WIDTH-1:0] adr,
  input logic [DATA_WIDTH-1:0] wdat,
  output logic [DATA_WIDTH-1:0] rdat
);
  logic [DATA_WIDTH-1:0] mem [2**MEM_ADR_WIDTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_WIDTH/8; i++)
      if (be[i]) mem[adr][8*i +: 8] <= wdat[8*i +: 8];
    rdat <= mem[adr];
  end
endmodule

// File: rtl/wb_bram_burst.sv
// wb_bram_burst: Wishbone B4 BRAM slave, registered read ack, CTI/BTE burst reads at one beat per cycle.
// Define WB_BRAM_BURST_ERR_EN to add an err port that rejects addresses beyond the memory depth.
module wb_bram_burst
  import wb_bram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_ADR_WIDTH = 11,
  parameter int ADR_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  input logic cyc,
  input logic stb,
  input logic we,
  input logic [ADR_WIDTH-1:0] adr,
  input logic [DATA_WIDTH/8-1:0] sel,
  input logic [DATA_WIDTH-1:0] dat_ms,
  input cti_t cti,
  input bte_t bte,
  output logic [DATA_WIDTH-1:0] dat_sm,
  output logic ack
`ifdef WB_BRAM_BURST_ERR_EN
  ,
  output logic err
`endif
);
  localparam int B = $clog2(DATA_WIDTH/8);
  localparam int MA = MEM_ADR_WIDTH;
  state_t state, state_n;
  logic [MA-1:0] wadr, pred, ram_adr, nxt;
  logic [DATA_WIDTH-1:0] rdat;
  logic wr, oob, hit, rd_ok, rd_err, unused_adr;
  assign wadr = adr[MA+B-1:B];
  assign unused_adr = ^adr;
`ifdef WB_BRAM_BURST_ERR_EN
  assign oob = |(adr >> (MA + B));
  assign err = (wr & oob) | (rd_ok & rd_err);
`else
  assign oob = 1'b0;
`endif
  assign wr = cyc & stb & we;
  assign nxt = MA'(next_adr(32'(pred), bte));
  assign hit = wadr == pred && !oob;
  // ram_adr is the word whose data will sit in rdat next cycle; pred tracks it.
  always_comb begin
    state_n = state;
    ram_adr = wadr;
    rd_ok = 1'b0;
    if (!cyc) state_n = IDLE;
    else if (stb && we) state_n = IDLE;
    else case (state)
      IDLE: state_n = stb ? RD1 : IDLE;
      RD1: if (!stb) ram_adr = pred;
           else begin
             rd_ok = 1'b1;
             ram_adr = cti == CTI_INCR && !rd_err ? nxt : wadr;
             state_n = cti == CTI_INCR && !rd_err ? BURST : IDLE;
           end
      BURST: if (!stb) ram_adr = pred;
             else if (hit) begin
               rd_ok = 1'b1;
               ram_adr = nxt;
               state_n = cti == CTI_INCR ? BURST : IDLE;
             end
             else state_n = RD1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pred <= '0;
      rd_err <= 1'b0;
    end else begin
      state <= state_n;
      pred <= ram_adr;
      rd_err <= state_n != RD1 ? 1'b0 : state == RD1 ? rd_err : oob;
    end
  assign ack = (wr & !oob) | (rd_ok & !rd_err);
  assign dat_sm = state != IDLE && !rd_err ? rdat : '0;
  bram_sp_bytewe #(.DATA_WIDTH(DATA_WIDTH), .MEM_ADR_WIDTH(MA)) u_ram (
    .clk(clk),
    .be(wr && !oob ? sel : '0),
    .adr(ram_adr),
    .wdat(dat_ms),
    .rdat(rdat)
  );
endmodule
